// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: bundles everything between the two write producers, the
// register file and the bypass network around rf_write_arbiter.
//   hold                     pipeline freeze, no grants while high
//   req0_valid/idx/val/ready port 0 (writeBack stage) request and same-cycle grant
//   req1_valid/idx/val/ready port 1 (multicycle unit) request and same-cycle grant
//   rf_wr_en/idx/val         register-file write port
//   bp_idx/bp_val            forwarding value, index 0 means nothing to forward
//   grant_src                producer that owns the current write stage (0/1)
// master: the producer/consumer side. slave: the arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_IDX = 5
);
    logic               hold;
    logic               req0_valid;
    logic [REG_IDX-1:0] req0_idx;
    logic [XLEN-1:0]    req0_val;
    logic               req0_ready;
    logic               req1_valid;
    logic [REG_IDX-1:0] req1_idx;
    logic [XLEN-1:0]    req1_val;
    logic               req1_ready;
    logic               rf_wr_en;
    logic [REG_IDX-1:0] rf_wr_idx;
    logic [XLEN-1:0]    rf_wr_val;
    logic [REG_IDX-1:0] bp_idx;
    logic [XLEN-1:0]    bp_val;
    logic               grant_src;

    modport master (
        output hold,
        output req0_valid, req0_idx, req0_val,
        input  req0_ready,
        output req1_valid, req1_idx, req1_val,
        input  req1_ready,
        input  rf_wr_en, rf_wr_idx, rf_wr_val,
        input  bp_idx, bp_val, grant_src
    );

    modport slave (
        input  hold,
        input  req0_valid, req0_idx, req0_val,
        output req0_ready,
        input  req1_valid, req1_idx, req1_val,
        output req1_ready,
        output rf_wr_en, rf_wr_idx, rf_wr_val,
        output bp_idx, bp_val, grant_src
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the single register-file write port between the
// writeBack stage (port 0) and the multicycle unit (port 1). Port 0 has priority,
// but port 1 wins outright once it has been denied STARVE_MAX consecutive cycles.
// The winner is registered into a one-entry write stage that drives the register
// file one cycle after the grant and doubles as the bypass source.
//   clk  clock, all state updates on posedge
//   rst  asynchronous reset, active-low
//   bus  rf_write_arbiter_if.slave: requests, grants, write port, bypass
module rf_write_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_IDX    = 5,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    rf_write_arbiter_if.slave  bus
);

    localparam int unsigned    CntW      = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr0  = 2'd1,
        StWr1  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [REG_IDX-1:0] idx_q, idx_d;
    logic [XLEN-1:0]    val_q, val_d;
    logic [CntW-1:0]    starve_q, starve_d;
    logic               grant0, grant1;
    logic               wr_en;

    // Grants are also masked by reset so every output reads 0 while rst is low.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst && !bus.hold) begin
            if (bus.req1_valid && (starve_q == StarveMax)) begin
                grant1 = 1'b1;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid & ~bus.req0_valid;
            end
        end
    end

    // Counts consecutive denials of a waiting port 1; frozen under hold.
    always_comb begin
        starve_d = starve_q;
        if (!bus.hold) begin
            if (!bus.req1_valid || grant1) begin
                starve_d = '0;
            end else if (starve_q != StarveMax) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            val_q    <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            starve_q <= starve_d;
        end
    end

    // Next state: the stage simply takes whatever was granted this cycle. Payload
    // is cleared on idle so the write-port outputs read 0 without extra gating.
    always_comb begin
        state_d = StIdle;
        idx_d   = '0;
        val_d   = '0;
        if (grant0) begin
            state_d = StWr0;
            idx_d   = bus.req0_idx;
            val_d   = bus.req0_val;
        end else if (grant1) begin
            state_d = StWr1;
            idx_d   = bus.req1_idx;
            val_d   = bus.req1_val;
        end
    end

    // Outputs. A write to x0 occupies the stage but never strobes or forwards.
    always_comb begin
        wr_en          = (state_q != StIdle) && (idx_q != '0);
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.rf_wr_en   = wr_en;
        bus.rf_wr_idx  = idx_q;
        bus.rf_wr_val  = val_q;
        bus.grant_src  = (state_q == StWr1);
        bus.bp_idx     = wr_en ? idx_q : '0;
        bus.bp_val     = wr_en ? val_q : '0;
    end

endmodule
